// File: rtl/theta_diffuse.sv
// theta_diffuse: applies Keccak theta diffusion to the state, one z slice per beat.
// A full column-parity plane C[x][z] is loaded first. Then each state slice
// A[.][.][z] is XORed with D[x][z] = C[x-1][z] ^ C[x+1][z-1], and all indices wrap.
// Optional build macro THETA_PROTO_ERR_EN adds a sticky proto_err output.
// This output flags handshake misuse.

module theta_diffuse #(
  parameter int SLICES = 64,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        par_valid,
  output logic        par_ready,
  input  logic [4:0]  par_data,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [24:0] st_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        done,
  output logic        busy
`ifdef THETA_PROTO_ERR_EN
  ,
  output logic        proto_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             in_last;   // all SLICES state beats accepted for this job

  logic [4:0]       par_mem [SLICES];
  logic [CNT_W-1:0] z_prev;
  logic [4:0]       c_cur;
  logic [4:0]       c_prev;
  logic [4:0]       d_col;

  logic             par_fire;
  logic             st_fire;
  logic             out_fire;

  // Handshake qualifiers and status outputs.
  // in_last stops input acceptance once every slice is taken, while the last result waits.
  assign par_ready = (state == S_LOAD);
  assign st_ready  = (state == S_APPLY) && !in_last && (!out_valid || out_ready);
  assign par_fire  = par_ready && par_valid;
  assign st_fire   = st_ready && st_valid;
  assign out_fire  = out_valid && out_ready;
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Parity plane lookup. z-1 wraps modulo SLICES through the counter width.
  assign z_prev = in_cnt - CNT_ONE;
  assign c_cur  = par_mem[in_cnt];
  assign c_prev = par_mem[z_prev];

  // Diffusion column D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][z-1].
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    d_col    = '0;
    d_col[0] = c_cur[4] ^ c_prev[1];
    d_col[1] = c_cur[0] ^ c_prev[2];
    d_col[2] = c_cur[1] ^ c_prev[3];
    d_col[3] = c_cur[2] ^ c_prev[4];
    d_col[4] = c_cur[3] ^ c_prev[0];
  end

  // Parity plane storage, written one row per accepted parity beat.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset. Every job rewrites all rows before any read.
    if (par_fire) begin
      par_mem[in_cnt] <= par_data;
    end
  end

  // Control FSM, slice counters and output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            in_cnt  <= '0;
            out_cnt <= '0;
            in_last <= 1'b0;
          end
        end
        S_LOAD: begin
          if (par_fire) begin
            in_cnt <= in_cnt + CNT_ONE;
            if (in_cnt == CNT_MAX) begin
              state  <= S_APPLY;
              in_cnt <= '0;
            end
          end
        end
        S_APPLY: begin
          if (st_fire) begin
            out_data <= st_data ^ {5{d_col}};
            in_cnt   <= in_cnt + CNT_ONE;
            if (in_cnt == CNT_MAX) begin
              in_last <= 1'b1;
            end
          end
          // A new accept overrides the drain of the old beat, so no bubble is added.
          if (st_fire) begin
            out_valid <= 1'b1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (out_fire) begin
            out_cnt <= out_cnt + CNT_ONE;
            if (out_cnt == CNT_MAX) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef THETA_PROTO_ERR_EN
  // Sticky protocol-error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if ((state == S_LOAD && st_valid) ||
                 (state == S_APPLY && par_valid) ||
                 (start && busy)) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_theta_diffuse.sv
// Directed testbench for theta_diffuse. Expected results are hand-derived flip masks per slice.
// Define THETA_PROTO_ERR_EN to also exercise the proto_err option.

module tb_theta_diffuse;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        par_valid;
  logic        par_ready;
  logic [4:0]  par_data;
  logic        st_valid;
  logic        st_ready;
  logic [24:0] st_data;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_data;
  logic        done;
  logic        busy;
`ifdef THETA_PROTO_ERR_EN
  logic        proto_err;
`endif

  int compared;
  int mismatched;

  logic [4:0]  par_tab  [64];
  logic [24:0] st_tab   [64];
  logic [24:0] flip_tab [64];

  // Hand-computed flip masks.
  localparam logic [24:0] M_X1 = 25'h0210842;  // bits 1,6,11,16,21
  localparam logic [24:0] M_X3 = 25'h0842108;  // bits 3,8,13,18,23
  localparam logic [24:0] M_X4 = 25'h1084210;  // bits 4,9,14,19,24

  theta_diffuse #(.SLICES(64), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .par_data  (par_data),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_data   (st_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .busy      (busy)
`ifdef THETA_PROTO_ERR_EN
    ,
    .proto_err (proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_tabs(input bit counted_state);
    for (int z = 0; z < 64; z++) begin
      par_tab[z]  = 5'h0;
      flip_tab[z] = 25'h0;
      if (counted_state) st_tab[z] = {z[4:0], 20'h0};
      else               st_tab[z] = 25'(z * 32'h0012_3457 + 32'h1A5);
    end
  endtask

  // Runs one job. stall_at/abort_at < 0 disable the stall and abort. st_pulse drives st_valid once in LOAD.
  task automatic do_job(input int stall_at, input int stall_len, input int abort_at, input bit st_pulse);
    int in_idx, out_idx, cyc, stall_cnt;
    bit load_ok, stalling;
    logic [24:0] exp_v;
    in_idx = 0; out_idx = 0; cyc = 0; stall_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if (par_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL start_latency: par_ready=%b busy=%b, need 1 1", par_ready, busy);
    else ;
    if (par_ready !== 1'b1 || busy !== 1'b1) mismatched++;
    load_ok = 1'b1;
    for (int z = 0; z < 64; z++) begin
      par_valid = 1'b1;
      par_data  = par_tab[z];
      st_valid  = st_pulse && (z == 5);
      #1;
      if (par_ready !== 1'b1 || st_ready !== 1'b0) load_ok = 1'b0;
`ifdef THETA_PROTO_ERR_EN
      if (st_pulse && z == 7) begin
        compared++;
        if (proto_err !== 1'b1) begin
          mismatched++;
          $display("FAIL proto_set: proto_err=%b, need 1", proto_err);
        end
      end
`endif
      @(posedge clk); #1;
    end
    par_valid = 1'b0;
    st_valid  = 1'b0;
    compared++;
    if (!load_ok) begin
      mismatched++;
      $display("FAIL load_ready: par_ready/st_ready wrong during 64 LOAD cycles");
    end
    compared++;
    if (par_ready !== 1'b0 || st_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL load_exit: par_ready=%b st_ready=%b, need 0 1", par_ready, st_ready);
    end
    while (out_idx < 64 && cyc < 2000) begin
      if (abort_at >= 0 && out_idx == abort_at) break;
      st_valid  = (in_idx < 64);
      st_data   = (in_idx < 64) ? st_tab[in_idx] : 25'h0;
      out_ready = 1'b1;
      stalling  = 1'b0;
      if (out_idx == stall_at && out_valid === 1'b1 && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stalling  = 1'b1;
        stall_cnt++;
      end
      #1;
      exp_v = st_tab[out_idx] ^ flip_tab[out_idx];
      if (stalling) begin
        compared++;
        if (st_ready !== 1'b0 || out_data !== exp_v) begin
          mismatched++;
          $display("FAIL stall_hold: st_ready=%b out_data=%h, need 0 %h", st_ready, out_data, exp_v);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        compared++;
        if (out_data !== exp_v) begin
          mismatched++;
          $display("FAIL slice_%0d: out_data=%h, need %h", out_idx, out_data, exp_v);
        end
        out_idx++;
      end
      if (st_valid && st_ready === 1'b1) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    st_valid  = 1'b0;
    out_ready = 1'b1;
    if (abort_at >= 0 && out_idx == abort_at) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      compared++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || par_ready !== 1'b0 || st_ready !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_reset: out_valid=%b busy=%b par_ready=%b st_ready=%b done=%b, need all 0",
                 out_valid, busy, par_ready, st_ready, done);
      end
      return;
    end
    compared++;
    if (cyc >= 2000) begin
      mismatched++;
      $display("FAIL apply_timeout: %0d outputs seen, need 64", out_idx);
      return;
    end
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL done_pulse: done=%b busy=%b out_valid=%b, need 1 1 0", done, busy, out_valid);
    end
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL done_end: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; par_valid = 1'b0; par_data = 5'h0;
    st_valid = 1'b0; st_data = 25'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compared++;
    if (par_ready !== 1'b0 || st_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 25'h0 || done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: pr=%b sr=%b ov=%b od=%h done=%b busy=%b, need all 0",
               par_ready, st_ready, out_valid, out_data, done, busy);
    end
`ifdef THETA_PROTO_ERR_EN
    compared++;
    if (proto_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_proto: proto_err=%b, need 0", proto_err);
    end
`endif
  endtask

  task automatic test_zero_parity;
    clear_tabs(1'b1);
    do_job(-1, 0, -1, 1'b0);
  endtask

  task automatic test_single_c00;
    clear_tabs(1'b0);
    par_tab[0]  = 5'b00001;
    flip_tab[0] = M_X1;
    flip_tab[1] = M_X4;
    do_job(-1, 0, -1, 1'b0);
  endtask

  task automatic test_wrap;
    clear_tabs(1'b0);
    par_tab[63]  = 5'b00100;
    flip_tab[63] = M_X3;
    flip_tab[0]  = M_X1;
    do_job(-1, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure;
    clear_tabs(1'b0);
    par_tab[0]  = 5'b00001;
    flip_tab[0] = M_X1;
    flip_tab[1] = M_X4;
    do_job(10, 5, -1, 1'b0);
  endtask

  task automatic test_mid_reset;
    clear_tabs(1'b0);
    par_tab[63]  = 5'b00100;
    flip_tab[63] = M_X3;
    flip_tab[0]  = M_X1;
    do_job(-1, 0, 30, 1'b0);
    clear_tabs(1'b1);
    do_job(-1, 0, -1, 1'b0);
  endtask

`ifdef THETA_PROTO_ERR_EN
  task automatic test_proto_err;
    clear_tabs(1'b1);
    do_job(-1, 0, -1, 1'b1);
    compared++;
    if (proto_err !== 1'b1) begin
      mismatched++;
      $display("FAIL proto_sticky: proto_err=%b, need 1", proto_err);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    compared++;
    if (proto_err !== 1'b0) begin
      mismatched++;
      $display("FAIL proto_clear: proto_err=%b, need 0", proto_err);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_zero_parity();
    test_single_c00();
    test_wrap();
    test_backpressure();
    test_mid_reset();
`ifdef THETA_PROTO_ERR_EN
    test_proto_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
